// File: rtl/decoder_pkg.sv
// ============================================================================
// decoder_pkg : shared types and constants for the decoder_seq block
// Rev 1.0
// ============================================================================
`default_nettype none

package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        PULSE = 2'd2
    } state_t;

    typedef enum logic {
        MODE_LEVEL = 1'b0,
        MODE_PULSE = 1'b1
    } mode_t;

    localparam int CNT_W = 8;

endpackage

`default_nettype wire

// File: rtl/onehot_dec.sv
// ============================================================================
// onehot_dec : combinational code to one-hot decoder, all-zero when out of range
// Rev 1.0
// ============================================================================
`default_nettype none

module onehot_dec #(
    parameter int IN_W    = 3,
    parameter int NUM_OUT = 8
) (
    input  logic [IN_W-1:0]    code,
    output logic [0:NUM_OUT-1] dec,
    output logic               in_range
);

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_bit
        assign dec[k] = (code == IN_W'(k));
    end

    // Every legal code lights exactly one bit, so an empty vector means out of range.
    assign in_range = |dec;

endmodule

`default_nettype wire

// File: rtl/decoder_seq.sv
// ============================================================================
// decoder_seq : registered one-hot decoder with level (hold) and pulse modes
// Optional sticky out-of-range flag: define DECODER_ERR_EN. Rev 1.0
// ============================================================================
`default_nettype none

module decoder_seq
    import decoder_pkg::*;
#(
    parameter int IN_W      = 3,
    parameter int NUM_OUT   = 8,
    parameter int PULSE_LEN = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_code,
    input  logic               in_mode,
    input  logic               clr,
    output logic [0:NUM_OUT-1] out,
    output logic               busy
`ifdef DECODER_ERR_EN
    ,
    output logic               err
`endif
);

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [0:NUM_OUT-1] dec;
    logic               dec_valid;
    logic               accept;

    onehot_dec #(
        .IN_W    (IN_W),
        .NUM_OUT (NUM_OUT)
    ) u_dec (
        .code     (in_code),
        .dec      (dec),
        .in_range (dec_valid)
    );

    assign in_ready = (state != PULSE);
    assign busy     = (state == PULSE);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            state <= IDLE;
            out   <= '0;
            cnt   <= '0;
        end else if (accept) begin
            if (!dec_valid) begin
                state <= IDLE;
                out   <= '0;
                cnt   <= '0;
            end else if (mode_t'(in_mode) == MODE_PULSE) begin
                state <= PULSE;
                out   <= dec;
                cnt   <= PULSE_LOAD;
            end else begin
                state <= HOLD;
                out   <= dec;
                cnt   <= '0;
            end
        end else if (state == PULSE) begin
            // Counter reading zero marks the last visible pulse cycle.
            if (cnt == '0) begin
                state <= IDLE;
                out   <= '0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

`ifdef DECODER_ERR_EN
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            err <= 1'b0;
        end else if (accept && !dec_valid) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_decoder_seq.sv
// ============================================================================
// tb_decoder_seq : directed vector table, corner sequences and random run vs model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_decoder_seq;

    localparam int IN_W      = 3;
    localparam int NUM_OUT   = 6;
    localparam int PULSE_LEN = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [IN_W-1:0]    in_code;
    logic               in_mode;
    logic               clr;
    logic [0:NUM_OUT-1] out;
    logic               busy;
`ifdef DECODER_ERR_EN
    logic               err;
`endif

    always #5 clk = ~clk;

    decoder_seq #(
        .IN_W      (IN_W),
        .NUM_OUT   (NUM_OUT),
        .PULSE_LEN (PULSE_LEN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_code  (in_code),
        .in_mode  (in_mode),
        .clr      (clr),
        .out      (out),
        .busy     (busy)
`ifdef DECODER_ERR_EN
        ,
        .err      (err)
`endif
    );

    typedef struct packed {
        logic               rst_n;
        logic               clr;
        logic               valid;
        logic               mode;
        logic [IN_W-1:0]    code;
        logic [0:NUM_OUT-1] out;
        logic               busy;
        logic               ready;
        logic               err;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: the visible code (-1 = none) and the number of
    // pulse cycles still to be shown including the current one.
    int   m_code = -1;
    int   m_left = 0;
    logic m_err  = 1'b0;

    function automatic logic [0:NUM_OUT-1] m_out();
        logic [0:NUM_OUT-1] v;
        v = '0;
        if (m_code >= 0) v[m_code] = 1'b1;
        return v;
    endfunction

    task automatic model_step();
        bit ready;
        ready = (m_left == 0);
        if (!rst_n || clr) begin
            m_code = -1; m_left = 0; m_err = 1'b0;
        end else if (in_valid && ready) begin
            if (int'(in_code) >= NUM_OUT) begin
                m_code = -1; m_left = 0; m_err = 1'b1;
            end else begin
                m_code = int'(in_code);
                m_left = in_mode ? PULSE_LEN : 0;
            end
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) m_code = -1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic c, input logic v, input logic m,
                         input logic [IN_W-1:0] code);
        rst_n = r; clr = c; in_valid = v; in_mode = m; in_code = code;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " out"},    32'(out),   32'(m_out()));
        chk({tag, " busy"},   32'(busy),  32'(m_left > 0));
        chk({tag, " ready"},  32'(in_ready), 32'(m_left == 0));
        chk({tag, " onehot"}, 32'($countones(out) <= 1), 32'd1);
`ifdef DECODER_ERR_EN
        chk({tag, " err"},    32'(err),   32'(m_err));
`endif
    endtask

    function automatic void add(input logic r, input logic c, input logic v, input logic m,
                                input logic [IN_W-1:0] code, input logic [0:NUM_OUT-1] o,
                                input logic b, input logic rdy, input logic e);
        vecs.push_back('{r, c, v, m, code, o, b, rdy, e});
    endfunction

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_code = '0;

        // rst clr val mode code  out        busy rdy err
        add(0, 0, 0, 0, 3'd0, 6'b000000, 0, 1, 0);
        add(1, 0, 0, 0, 3'd0, 6'b000000, 0, 1, 0);
        add(1, 0, 1, 0, 3'd2, 6'b001000, 0, 1, 0);
        for (int i = 0; i < 10; i++) add(1, 0, 0, 0, 3'd0, 6'b001000, 0, 1, 0);
        add(1, 0, 1, 1, 3'd5, 6'b000001, 1, 0, 0);
        add(1, 0, 1, 0, 3'd3, 6'b000001, 1, 0, 0);
        add(1, 0, 1, 0, 3'd3, 6'b000001, 1, 0, 0);
        add(1, 0, 0, 0, 3'd0, 6'b000000, 0, 1, 0);
        add(1, 0, 1, 0, 3'd1, 6'b010000, 0, 1, 0);
        add(1, 0, 1, 0, 3'd4, 6'b000010, 0, 1, 0);
        add(1, 0, 0, 0, 3'd0, 6'b000010, 0, 1, 0);
        add(1, 0, 1, 1, 3'd0, 6'b100000, 1, 0, 0);
        add(1, 1, 0, 0, 3'd0, 6'b000000, 0, 1, 0);
        add(1, 1, 1, 0, 3'd3, 6'b000000, 0, 1, 0);
        add(1, 0, 0, 0, 3'd0, 6'b000000, 0, 1, 0);
        add(1, 0, 1, 0, 3'd2, 6'b001000, 0, 1, 0);
        add(1, 0, 1, 0, 3'd7, 6'b000000, 0, 1, 1);
        for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 3'd0, 6'b000000, 0, 1, 1);
        add(1, 1, 0, 0, 3'd0, 6'b000000, 0, 1, 0);
        add(1, 0, 1, 1, 3'd6, 6'b000000, 0, 1, 1);
        add(1, 0, 1, 0, 3'd3, 6'b000100, 0, 1, 1);
        add(1, 0, 0, 0, 3'd0, 6'b000100, 0, 1, 1);
        add(0, 0, 0, 0, 3'd0, 6'b000000, 0, 1, 0);
        add(1, 0, 0, 0, 3'd0, 6'b000000, 0, 1, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].clr, vecs[i].valid, vecs[i].mode, vecs[i].code);
            chk($sformatf("vec%0d out", i),    32'(out),      32'(vecs[i].out));
            chk($sformatf("vec%0d busy", i),   32'(busy),     32'(vecs[i].busy));
            chk($sformatf("vec%0d ready", i),  32'(in_ready), 32'(vecs[i].ready));
            chk($sformatf("vec%0d onehot", i), 32'($countones(out) <= 1), 32'd1);
`ifdef DECODER_ERR_EN
            chk($sformatf("vec%0d err", i),    32'(err),      32'(vecs[i].err));
`endif
        end

        // Reset asserted mid-pulse with the sticky flag set beforehand.
        drive(1, 0, 1, 0, 3'd7);
        check_model("seq_oor");
        drive(1, 0, 1, 1, 3'd4);
        check_model("seq_pulse0");
        chk("seq_pulse0 out", 32'(out), 32'(6'b000010));
        drive(1, 0, 0, 0, 3'd0);
        check_model("seq_pulse1");
        drive(0, 0, 0, 0, 3'd0);
        check_model("seq_rst");
        chk("seq_rst out",  32'(out),  32'd0);
        chk("seq_rst busy", 32'(busy), 32'd0);
`ifdef DECODER_ERR_EN
        chk("seq_rst err",  32'(err),  32'd0);
`endif
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 3'd0);
            check_model("seq_post");
        end

        // Pulse run to completion, then a pulse followed immediately by a hold.
        drive(1, 0, 1, 1, 3'd1);
        check_model("seq_p2a");
        for (int i = 0; i < PULSE_LEN + 1; i++) begin
            drive(1, 0, 1, 0, 3'd2);
            check_model("seq_p2b");
        end

        for (int i = 0; i < 3000; i++) begin
            drive(logic'($urandom_range(0, 49) != 0),
                  logic'($urandom_range(0, 19) == 0),
                  logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 1)),
                  IN_W'($urandom_range(0, 7)));
            check_model("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
